// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pcie_phy_pkg
// Description : Definitions shared by the PHY serial stages. Holds the
//               comma/idle symbol (also used by the TX serializer) and the
//               receive-alignment state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // Comma/idle symbol that marks byte alignment on the serial lane.
    localparam logic [7:0] c_com_byte = 8'hBC;

    // Receive alignment states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage : pcie_phy_pkg
`default_nettype wire

// File: rtl/comma_detect.sv
`default_nettype none
// ============================================================================
// Module      : comma_detect
// Description : Serial shift register with a comma compare on the value the
//               register is about to take, so a match is reported on the same
//               edge that samples the last bit of the symbol.
// Ports       : clk_32f  in  1  bit clock
//               reset_L  in  1  asynchronous active-low reset
//               data_in  in  1  serial bit, MSB first
//               sr_next  out 8  shift register contents including data_in
//               com_hit  out 1  sr_next equals COM_BYTE
// Revision    : 1.0 - initial release
// ============================================================================
module comma_detect
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COM_BYTE = c_com_byte
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] sr_next,
    output logic       com_hit
);

    // Only the seven most recent bits need storing: the oldest bit of the
    // byte window falls out on the very edge the new bit arrives.
    logic [6:0] r_sr;

    assign sr_next = {r_sr, data_in};
    assign com_hit = (sr_next == COM_BYTE);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_sr <= 7'd0;
        end else begin
            r_sr <= sr_next[6:0];
        end
    end

endmodule : comma_detect
`default_nettype wire

// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo
// Description : Serial-to-parallel receive stage. Recovers MSB-first bytes
//               from a 1-bit lane, finds the byte boundary from COM symbols
//               and locks after COM_LOCK consecutive aligned COMs. When
//               locked, emits one byte per 8 bit-times; COM bytes are
//               reported as idle (valid_out=0).
// Ports       : clk_32f    in  1  bit clock, one bit per rising edge
//               reset_L    in  1  asynchronous active-low reset
//               data_in    in  1  serial bit, MSB first
//               data_out   out 8  recovered byte, held between strobes
//               valid_out  out 1  1 = data byte, 0 = COM/idle
//               byte_stb   out 1  one-cycle pulse on output update
//               active     out 1  1 while LOCKED
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0]  COM_BYTE = c_com_byte,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    localparam int                  c_cnt_w       = $clog2(COM_LOCK + 1);
    localparam logic [c_cnt_w-1:0]  c_com_lock    = c_cnt_w'(COM_LOCK);
    localparam logic [c_cnt_w-1:0]  c_com_lock_m1 = c_cnt_w'(COM_LOCK - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);

    logic [7:0]         w_sr_next;
    logic               w_com_hit;
    logic               w_boundary;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_cnt_next;
    logic [c_cnt_w-1:0] r_com_cnt;
    logic [c_cnt_w-1:0] w_com_cnt_next;

    logic [7:0]         r_data_out;
    logic [7:0]         w_data_out_next;
    logic               r_valid_out;
    logic               w_valid_out_next;
    logic               r_byte_stb;
    logic               w_byte_stb_next;
    logic               r_active;

    comma_detect #(
        .COM_BYTE (COM_BYTE)
    ) u_comma_detect (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .data_in (data_in),
        .sr_next (w_sr_next),
        .com_hit (w_com_hit)
    );

    // The edge on which the last bit of an aligned byte is sampled.
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt + 3'd1;
        w_com_cnt_next   = r_com_cnt;
        w_data_out_next  = r_data_out;
        w_valid_out_next = r_valid_out;
        w_byte_stb_next  = 1'b0;

        case (r_state)
            HUNT: begin
                // Any bit offset is a candidate; the hit edge becomes bit 7
                // of the byte grid, so the counter restarts at 0.
                if (w_com_hit) begin
                    w_state_next   = ALIGN;
                    w_bit_cnt_next = 3'd0;
                    w_com_cnt_next = c_cnt_one;
                end
            end

            ALIGN: begin
                // Only boundary edges matter; mid-byte matches are ignored.
                if (w_boundary) begin
                    if (w_com_hit) begin
                        if (r_com_cnt == c_com_lock_m1) begin
                            w_state_next   = LOCKED;
                            w_com_cnt_next = c_com_lock;
                        end else begin
                            w_com_cnt_next = r_com_cnt + c_cnt_one;
                        end
                    end else begin
                        w_state_next   = HUNT;
                        w_com_cnt_next = '0;
                    end
                end
            end

            LOCKED: begin
                if (w_boundary) begin
                    w_data_out_next  = w_sr_next;
                    w_valid_out_next = !w_com_hit;
                    w_byte_stb_next  = 1'b1;
                end
            end

            default: begin
                w_state_next   = HUNT;
                w_com_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= HUNT;
            r_bit_cnt   <= 3'd0;
            r_com_cnt   <= '0;
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_com_cnt   <= w_com_cnt_next;
            r_data_out  <= w_data_out_next;
            r_valid_out <= w_valid_out_next;
            r_byte_stb  <= w_byte_stb_next;
            r_active    <= (w_state_next == LOCKED);
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign byte_stb  = r_byte_stb;
    assign active    = r_active;

endmodule : serial_paralelo
`default_nettype wire
